// File: rtl/mareg_feeder_if.sv
// ---------------------------------------------------------------------------
// mareg_feeder_if
//   Operand stream between the feeder (producer) and the mareg MAC register
//   (consumer). One (x, w) pair per cycle, framed by valid/last, with a
//   consumer-driven stall.
//   Signals:
//     out_x, out_w  OPW bits  operand pair, forced to 0 when out_valid=0
//     out_valid     1         pair is live
//     out_last      1         pair is the final one of the burst
//     stall         1         consumer not ready, producer holds its outputs
//   Modports:
//     master  producer side (drives operands, samples stall)
//     slave   consumer side (samples operands, drives stall)
// ---------------------------------------------------------------------------
interface mareg_feeder_if #(
    parameter int OPW = 2
) ();
    logic [OPW-1:0] out_x;
    logic [OPW-1:0] out_w;
    logic           out_valid;
    logic           out_last;
    logic           stall;

    modport master (
        output out_x,
        output out_w,
        output out_valid,
        output out_last,
        input  stall
    );

    modport slave (
        input  out_x,
        input  out_w,
        input  out_valid,
        input  out_last,
        output stall
    );
endinterface

// File: rtl/mareg_feeder.sv
// ---------------------------------------------------------------------------
// mareg_feeder
//   Operand sequencer for a mareg MAC register. The host fills a DEPTH-entry
//   buffer of (x, w) pairs while the block is idle, then pulses start with a
//   burst length. The feeder streams the pairs one per cycle over the operand
//   interface, honours stall, and pulses done once the last pair is consumed.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset (clears state and buffer)
//     wr_en    buffer write strobe, honoured only while busy=0
//     wr_addr  buffer write address (AW bits)
//     wr_x     x operand to write (OPW bits)
//     wr_w     w operand to write (OPW bits)
//     start    begin a burst, sampled only in IDLE
//     len      burst length (AW+1 bits), saturated to DEPTH
//     op       operand stream, master side (out_x/out_w/out_valid/out_last, stall)
//     busy     registered, high whenever the FSM is not IDLE
//     done     registered one-cycle pulse at end of burst
// ---------------------------------------------------------------------------
module mareg_feeder #(
    parameter int mareg_input_width = 4,
    parameter int DEPTH             = 8,
    localparam int OPW              = mareg_input_width / 2,
    localparam int AW               = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [OPW-1:0]       wr_x,
    input  logic [OPW-1:0]       wr_w,
    input  logic                 start,
    input  logic [AW:0]          len,
    mareg_feeder_if.master       op,
    output logic                 busy,
    output logic                 done
);

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state_r;
    logic [OPW-1:0] mem_x_r [DEPTH];
    logic [OPW-1:0] mem_w_r [DEPTH];
    logic [AW:0]    idx_r;
    logic [AW:0]    len_r;
    logic [AW:0]    len_sat_s;

    // Saturate the requested burst length to the buffer depth.
    always_comb begin
        len_sat_s = len;
        if (len > DEPTH_V) begin
            len_sat_s = DEPTH_V;
        end else begin
            len_sat_s = len;
        end
    end

    // Operand buffer: cleared on reset, writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_r[i] <= {OPW{1'b0}};
                mem_w_r[i] <= {OPW{1'b0}};
            end
        end else if (wr_en && !busy) begin
            mem_x_r[wr_addr] <= wr_x;
            mem_w_r[wr_addr] <= wr_w;
        end
    end

    // Burst sequencer with registered stream outputs, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {(AW+1){1'b0}};
            len_r        <= {(AW+1){1'b0}};
            op.out_x     <= {OPW{1'b0}};
            op.out_w     <= {OPW{1'b0}};
            op.out_valid <= 1'b0;
            op.out_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len == {(AW+1){1'b0}}) begin
                            // Empty burst: straight to the done pulse.
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r      <= ST_STREAM;
                            len_r        <= len_sat_s;
                            op.out_x     <= mem_x_r[0];
                            op.out_w     <= mem_w_r[0];
                            op.out_valid <= 1'b1;
                            op.out_last  <= (len_sat_s == {{AW{1'b0}}, 1'b1});
                            idx_r        <= {{AW{1'b0}}, 1'b1};
                        end
                    end
                end
                ST_STREAM: begin
                    if (!op.stall) begin
                        if (op.out_last) begin
                            // Final pair consumed: blank the bus so mareg adds nothing.
                            op.out_x     <= {OPW{1'b0}};
                            op.out_w     <= {OPW{1'b0}};
                            op.out_valid <= 1'b0;
                            op.out_last  <= 1'b0;
                            state_r      <= ST_DONE;
                            done         <= 1'b1;
                        end else begin
                            // idx_r only reaches L here while out_last is set, so
                            // the buffer is never read past L-1.
                            op.out_x    <= mem_x_r[idx_r[AW-1:0]];
                            op.out_w    <= mem_w_r[idx_r[AW-1:0]];
                            op.out_last <= (idx_r == (len_r - {{AW{1'b0}}, 1'b1}));
                            idx_r       <= idx_r + {{AW{1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= {(AW+1){1'b0}};
                    len_r        <= {(AW+1){1'b0}};
                    op.out_x     <= {OPW{1'b0}};
                    op.out_w     <= {OPW{1'b0}};
                    op.out_valid <= 1'b0;
                    op.out_last  <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule
